sram_port_arbiter: RTL

- Shares one single-ported SRAM macro between the CPU instruction-fetch requester (IM, read-only) and the data-memory requester (DM, read/write).
- Arbitrates per cycle, drives the SRAM control pins, and routes the 1-cycle-latency read data back to the requester that issued the read.
- Sits between the CPU core's im_*/dm_* interfaces and the shared SRAM. The core stalls while its request is not granted.

---
 rtl/sram_port_arbiter_if.sv | 40 ++++
 rtl/sram_port_arbiter.sv | 96 +++++++++
 2 files changed

// File: rtl/sram_port_arbiter_if.sv
// Core-side request/response and SRAM pin bundle for the shared SRAM port.
// The arbiter takes the slave view; the core plus SRAM model take the master view.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic              im_gnt;
    logic              im_rvalid;
    logic [DATA_W-1:0] im_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [DATA_W-1:0] dm_bweb;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              sram_ceb;
    logic              sram_web;
    logic [DATA_W-1:0] sram_bweb;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_din;
    logic [DATA_W-1:0] sram_dout;

    modport slave (
        input  im_req, im_addr, dm_req, dm_we, dm_bweb, dm_addr, dm_wdata, sram_dout,
        output im_gnt, im_rvalid, im_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output sram_ceb, sram_web, sram_bweb, sram_addr, sram_din
    );

    modport master (
        output im_req, im_addr, dm_req, dm_we, dm_bweb, dm_addr, dm_wdata, sram_dout,
        input  im_gnt, im_rvalid, im_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  sram_ceb, sram_web, sram_bweb, sram_addr, sram_din
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported SRAM between instruction fetch (IM) and data memory (DM),
// one access per cycle, returning 1-cycle-latency read data to the issuing requester.
module sram_port_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3,
    parameter int RR_MODE      = 0
) (
    input  logic                clk,
    input  logic                rst,
    sram_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IM   = 2'b01,
        OWN_DM   = 2'b10
    } owner_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]        starve_q, starve_d;
    logic              last_dm_q, last_dm_d;
    owner_e            rd_owner_q, rd_owner_d;
    logic [DATA_W-1:0] im_rdata_q, im_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              im_prio, im_gnt, dm_gnt, im_rvalid, dm_rvalid;

    // im_prio says who wins a conflict: starvation guard or round-robin pointer.
    always_comb begin
        if (RR_MODE != 0) im_prio = last_dm_q;
        else              im_prio = (starve_q == LIMIT);
        dm_gnt    = !rst && bus.dm_req && !(bus.im_req && im_prio);
        im_gnt    = !rst && bus.im_req && !dm_gnt;
        // Gating with rst drops the return of a read granted just before reset.
        im_rvalid = !rst && (rd_owner_q == OWN_IM);
        dm_rvalid = !rst && (rd_owner_q == OWN_DM);
    end

    always_comb begin
        bus.im_gnt    = im_gnt;
        bus.dm_gnt    = dm_gnt;
        bus.im_rvalid = im_rvalid;
        bus.dm_rvalid = dm_rvalid;
        bus.im_rdata  = im_rvalid ? bus.sram_dout : im_rdata_q;
        bus.dm_rdata  = dm_rvalid ? bus.sram_dout : dm_rdata_q;

        bus.sram_ceb  = 1'b1;
        bus.sram_web  = 1'b1;
        bus.sram_bweb = '1;
        bus.sram_addr = {ADDR_W{1'b0}};
        bus.sram_din  = {DATA_W{1'b0}};
        if (dm_gnt) begin
            bus.sram_ceb  = 1'b0;
            bus.sram_web  = !bus.dm_we;
            bus.sram_bweb = bus.dm_we ? bus.dm_bweb : '1;
            bus.sram_addr = bus.dm_addr;
            bus.sram_din  = bus.dm_wdata;
        end else if (im_gnt) begin
            bus.sram_ceb  = 1'b0;
            bus.sram_addr = bus.im_addr;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (RR_MODE != 0 || !bus.im_req || im_gnt) starve_d = 4'd0;
        else if (starve_q < LIMIT)                 starve_d = starve_q + 4'd1;

        last_dm_d = last_dm_q;
        if (dm_gnt)      last_dm_d = 1'b1;
        else if (im_gnt) last_dm_d = 1'b0;

        rd_owner_d = OWN_NONE;
        if (im_gnt)                    rd_owner_d = OWN_IM;
        else if (dm_gnt && !bus.dm_we) rd_owner_d = OWN_DM;

        im_rdata_d = im_rvalid ? bus.sram_dout : im_rdata_q;
        dm_rdata_d = dm_rvalid ? bus.sram_dout : dm_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q   <= 4'd0;
            last_dm_q  <= 1'b1;
            rd_owner_q <= OWN_NONE;
            im_rdata_q <= {DATA_W{1'b0}};
            dm_rdata_q <= {DATA_W{1'b0}};
        end else begin
            starve_q   <= starve_d;
            last_dm_q  <= last_dm_d;
            rd_owner_q <= rd_owner_d;
            im_rdata_q <= im_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end
endmodule
